// File: rtl/mem_copy_master.sv
// mem_copy_master
//   Bus initiator for the PicoRV32 native memory interface. It copies a block
//   of 32-bit words from src_addr to dst_addr. Each word is one read followed
//   by one write, and every transaction is followed by a one-cycle idle gap.
//
// Ports
//   clk, resetn          clock (rising edge) and async active-low reset
//   start                one-cycle request, honoured only in IDLE
//   src_addr, dst_addr   byte addresses; bits [1:0] are dropped
//   len_words            words to copy (0 completes immediately)
//   busy                 copy in progress
//   done                 one-cycle completion pulse
//   mem_valid/mem_ready  request / completion handshake
//   mem_addr, mem_wdata, mem_wstrb, mem_rdata  native bus payload
//
// Every output is decoded from registered state only. No input has a
// combinational path to an output.
module mem_copy_master (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_GAP = 3'd2,
    WR     = 3'd3,
    WR_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] src_ptr, dst_ptr, data_reg;
  logic [15:0] cnt;

  // mem_valid is high in RD and WR, so mem_ready alone marks the handshake there.
  logic rd_hs, wr_hs;
  assign rd_hs = (state == RD) && mem_ready;
  assign wr_hs = (state == WR) && mem_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_words == 16'd0) ? DONE : RD;
      RD:      if (mem_ready) state_nxt = RD_GAP;
      // The gap matters: the BRAM responder registers ready from valid, so
      // valid held into the next transaction would complete it at once.
      RD_GAP:  state_nxt = WR;
      WR:      if (mem_ready) state_nxt = (cnt == 16'd1) ? DONE : WR_GAP;
      WR_GAP:  state_nxt = RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_ptr  <= 32'h0;
      dst_ptr  <= 32'h0;
      data_reg <= 32'h0;
      cnt      <= 16'h0;
    end else begin
      if ((state == IDLE) && start && (len_words != 16'd0)) begin
        src_ptr <= {src_addr[31:2], 2'b00};
        dst_ptr <= {dst_addr[31:2], 2'b00};
        cnt     <= len_words;
      end
      if (rd_hs) data_reg <= mem_rdata;
      if (wr_hs) begin
        // Natural 32-bit overflow gives the required wrap past 0xFFFFFFFC.
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
        cnt     <= cnt - 16'd1;
      end
    end
  end

  assign busy      = (state == RD) || (state == RD_GAP) || (state == WR) || (state == WR_GAP);
  assign done      = (state == DONE);
  assign mem_valid = (state == RD) || (state == WR);
  assign mem_addr  = (state == WR) ? dst_ptr : src_ptr;
  assign mem_wdata = data_reg;
  assign mem_wstrb = (state == WR) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master. It uses a BRAM-like responder with a
// programmable number of wait states and a sparse memory.
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len_words = 16'h0;
  logic        busy, done, mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_copy_master dut (
    .clk(clk), .resetn(resetn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Responder and memory
  logic [31:0] mem [logic [31:0]];
  logic        rdy = 1'b0;
  logic [31:0] rdata = 32'h0;
  int          wcnt = 0;
  int          wait_n = 0;
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = 32'h0, pl_data = 32'h0;

  assign mem_ready = rdy;
  assign mem_rdata = rdata;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] = pl_data;
    if (mem_valid && mem_ready && (mem_wstrb == 4'hF)) mem[mem_addr] = mem_wdata;
    if (mem_valid && !rdy) begin
      rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      if (wcnt == wait_n) begin
        rdy  <= 1'b1;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      rdy  <= 1'b0;
      wcnt <= 0;
    end
  end

  // Bus monitor: counts done pulses, logs handshake addresses and flags
  // payload changes while a request is pending.
  logic        mon_clr = 1'b0;
  int          done_cnt = 0;
  int          stab_err = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic        pend = 1'b0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;

  always @(negedge clk) begin
    if (mon_clr) begin
      done_cnt = 0;
      stab_err = 0;
      rd_q.delete();
      wr_q.delete();
      pend = 1'b0;
    end else if (!resetn) begin
      pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (mem_valid && mem_ready) begin
        if (mem_wstrb == 4'hF) wr_q.push_back(mem_addr);
        else                   rd_q.push_back(mem_addr);
      end
      if (pend && (!mem_valid || mem_addr != p_addr || mem_wdata != p_wdata || mem_wstrb != p_wstrb))
        stab_err++;
      pend    = mem_valid && !mem_ready;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_wstrb = mem_wstrb;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic clr;
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (start is sampled at edge 0).
  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done. c counts cycles from cycle 1; a timeout is reported as a failure.
  task automatic wait_done(input int limit, output int c);
    c = 1;
    while (!done && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (!done) chk("done timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rnd [8];
  int          cyc;
  int          t;
  logic        act;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy",  busy, 0);
    chk("rst done",  done, 0);
    chk("rst valid", mem_valid, 0);
    chk("rst addr",  mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst wstrb", mem_wstrb, 0);
    resetn = 1'b1;

    // Zero-wait copy of 4 words, checked cycle by cycle
    preload(32'h000, 32'h11111111);
    preload(32'h004, 32'h22222222);
    preload(32'h008, 32'h33333333);
    preload(32'h00C, 32'h44444444);
    clr();
    go(32'h000, 32'h100, 16'd4);
    for (int c = 1; c <= 26; c++) begin
      chk($sformatf("busy c%0d", c),  busy, 32'(c <= 23));
      chk($sformatf("done c%0d", c),  done, 32'(c == 24));
      chk($sformatf("valid c%0d", c), mem_valid, 32'((c <= 23) && (c % 3 != 0)));
      @(negedge clk);
    end
    chk("cp4 w0", rd(32'h100), 32'h11111111);
    chk("cp4 w1", rd(32'h104), 32'h22222222);
    chk("cp4 w2", rd(32'h108), 32'h33333333);
    chk("cp4 w3", rd(32'h10C), 32'h44444444);
    chk("cp4 ndone", done_cnt, 1);
    chk("cp4 stable", stab_err, 0);

    // len 0
    clr();
    go(32'h000, 32'h200, 16'd0);
    chk("len0 done c1",  done, 1);
    chk("len0 busy c1",  busy, 0);
    chk("len0 valid c1", mem_valid, 0);
    act = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      act = act | busy | done | mem_valid;
    end
    chk("len0 quiet", act, 0);
    chk("len0 nwr", wr_q.size(), 0);
    chk("len0 nrd", rd_q.size(), 0);

    // Start pulses during a copy and in its DONE cycle are ignored
    clr();
    go(32'h000, 32'h180, 16'd4);
    repeat (8) @(negedge clk);
    src_addr = 32'h200; dst_addr = 32'h300; len_words = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("ign done c24", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("ign ndone", done_cnt, 1);
    chk("ign nwr", wr_q.size(), 4);
    chk("ign busy", busy, 0);
    chk("ign w0", rd(32'h180), 32'h11111111);
    chk("ign w3", rd(32'h18C), 32'h44444444);
    chk("ign 300", rd(32'h300), 32'h0);

    // Reset during the write of word 2
    clr();
    go(32'h000, 32'h1C0, 16'd4);
    t = 0;
    while (!(mem_valid && mem_wstrb == 4'hF && mem_addr == 32'h1C4) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst wr2 seen", mem_addr, 32'h1C4);
    resetn = 1'b0;
    #1;
    chk("mid rst valid", mem_valid, 0);
    chk("mid rst busy",  busy, 0);
    chk("mid rst done",  done, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    act = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      act = act | busy | done | mem_valid;
    end
    chk("post rst quiet", act, 0);
    chk("rst w0 kept", rd(32'h1C0), 32'h11111111);
    chk("rst w2 none", rd(32'h1C8), 32'h0);

    // Three wait states on every transaction, 8 words of random data
    wait_n = 3;
    for (int i = 0; i < 8; i++) begin
      rnd[i] = $urandom;
      preload(32'h400 + 32'(4 * i), rnd[i]);
    end
    clr();
    go(32'h400, 32'h500, 16'd8);
    wait_done(2000, cyc);
    chk("ws done cycle", cyc, 96);
    @(negedge clk);
    chk("ws stable", stab_err, 0);
    chk("ws ndone", done_cnt, 1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ws w%0d", i), rd(32'h500 + 32'(4 * i)), rnd[i]);

    // Address wrap and alignment
    wait_n = 0;
    preload(32'hFFFFFFFC, 32'hA5A5A5A5);
    clr();
    go(32'hFFFFFFFD, 32'h00000103, 16'd2);
    wait_done(200, cyc);
    chk("wrap done cycle", cyc, 12);
    @(negedge clk);
    chk("wrap nrd", rd_q.size(), 2);
    chk("wrap nwr", wr_q.size(), 2);
    if (rd_q.size() >= 2 && wr_q.size() >= 2) begin
      chk("wrap rd0", rd_q[0], 32'hFFFFFFFC);
      chk("wrap rd1", rd_q[1], 32'h00000000);
      chk("wrap wr0", wr_q[0], 32'h00000100);
      chk("wrap wr1", wr_q[1], 32'h00000104);
    end
    chk("wrap d0", rd(32'h100), 32'hA5A5A5A5);
    chk("wrap d1", rd(32'h104), 32'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
